// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layer compositor: fade FSM states,
// one-hot game status encodings, RGB colour struct and status decoder.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  // One-hot encodings of the existing game status bus.
  localparam logic [4:0] STATUS_SELECT = 5'b00001;
  localparam logic [4:0] STATUS_WAIT   = 5'b00010;
  localparam logic [4:0] STATUS_PLAY   = 5'b00100;
  localparam logic [4:0] STATUS_WIN    = 5'b01000;
  localparam logic [4:0] STATUS_LOSE   = 5'b10000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit position of a one-hot vector of the given width; any vector that is
  // not exactly one-hot (zero or multi-hot) maps to 'width', the invalid index.
  function automatic int onehot_to_idx(input logic [31:0] oh, input int width);
    int idx;
    int cnt;
    idx = width;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && oh[i]) begin
        idx = i;
        cnt++;
      end
    end
    if (cnt != 1) idx = width;
    return idx;
  endfunction

endpackage

// File: rtl/layer_compositor_fade_ctrl.sv
// Fade controller: on a status change the brightness level ramps down to
// black, the displayed palette switches while dark, then ramps back up.
// All level movement and state transitions happen on frame_start.
module fade_ctrl
  import compositor_pkg::*;
#(
  parameter int SW        = 3,
  parameter int FADE_BITS = 4,
  parameter int FADE_STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [SW-1:0]        req_idx,
  output logic [FADE_BITS:0]   level,
  output logic [SW-1:0]        disp_idx,
  output logic                 fade_busy
);

  localparam int FULL_I = 2 ** FADE_BITS;
  localparam int LIM_I  = FULL_I - FADE_STEP;
  localparam logic [FADE_BITS:0] FULL   = FULL_I[FADE_BITS:0];
  localparam logic [FADE_BITS:0] STEP   = FADE_STEP[FADE_BITS:0];
  localparam logic [FADE_BITS:0] UP_LIM = LIM_I[FADE_BITS:0];

  fade_state_t       state;
  logic [SW-1:0]     pend_idx;
  logic [FADE_BITS:0] lvl_dn;
  logic [FADE_BITS:0] lvl_up;

  // Saturating next levels for one fade step in either direction.
  assign lvl_dn    = (level > STEP) ? level - STEP : '0;
  assign lvl_up    = (level >= UP_LIM) ? FULL : level + STEP;
  assign fade_busy = (state != IDLE);

  // Fade state machine with level, displayed and pending status index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      level    <= FULL;
      disp_idx <= '0;
      pend_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start && req_idx != disp_idx) begin
            pend_idx <= req_idx;
            state    <= FADE_OUT;
          end
        end
        FADE_OUT: begin
          pend_idx <= req_idx;
          if (frame_start) begin
            level <= lvl_dn;
            if (lvl_dn == '0) begin
              disp_idx <= pend_idx;
              state    <= FADE_IN;
            end
          end
        end
        FADE_IN: begin
          if (frame_start) begin
            if (req_idx != disp_idx) begin
              pend_idx <= req_idx;
              state    <= FADE_OUT;
            end else begin
              level <= lvl_up;
              if (lvl_up == FULL) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Three-stage pixel compositor: priority-encodes layer hits, looks the colour
// up in a runtime-writable per-status palette (with optional background
// gradient), then scales by the fade level before driving the VGA pins.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int N_LAYERS  = 8,
  parameter int N_STATUS  = 5,
  parameter int FADE_BITS = 4,
  parameter int FADE_STEP = 2,
  parameter int GRAD_EN   = 1,
  localparam int N_ENTRIES = N_STATUS * (N_LAYERS + 1),
  localparam int AW        = $clog2(N_ENTRIES)
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                pix_valid,
  input  logic                frame_start,
  input  logic [N_STATUS-1:0] status,
  input  logic [N_LAYERS-1:0] layer_hit,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                pal_we,
  input  logic [AW-1:0]       pal_addr,
  input  logic [23:0]         pal_data,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                out_valid,
  output logic                fade_busy
);

  localparam int LW = $clog2(N_LAYERS + 1);
  localparam int SW = $clog2(N_STATUS + 1);

  rgb_t               palette [N_ENTRIES];
  logic [SW-1:0]      req_idx;
  logic [SW-1:0]      disp_idx;
  logic [FADE_BITS:0] level;
  logic [LW-1:0]      layer_enc;
  logic               s1_valid;
  logic [LW-1:0]      s1_layer;
  logic [6:0]         s1_xq;
  logic               s2_valid;
  rgb_t               s2_rgb;
  rgb_t               s2_next;
  rgb_t               pal_entry;
  logic [AW-1:0]      rd_addr;
  logic [7:0]         grad;
  logic               unused_bits;

  assign unused_bits = ^{DrawY, DrawX[2:0]};
  assign req_idx     = SW'(onehot_to_idx(32'(status), N_STATUS));

  fade_ctrl #(
    .SW        (SW),
    .FADE_BITS (FADE_BITS),
    .FADE_STEP (FADE_STEP)
  ) u_fade (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .frame_start (frame_start),
    .req_idx     (req_idx),
    .level       (level),
    .disp_idx    (disp_idx),
    .fade_busy   (fade_busy)
  );

  // Unsigned 8 x (FADE_BITS+1) multiply, keeping the integer part.
  function automatic logic [7:0] scale_chan(input logic [7:0] c,
                                            input logic [FADE_BITS:0] lvl);
    logic [8+FADE_BITS:0] p;
    p = {{(FADE_BITS+1){1'b0}}, c} * {8'd0, lvl};
    return p[FADE_BITS +: 8];
  endfunction

  // Palette storage, written synchronously; out-of-range addresses dropped.
  // NOTE: the palette must read as all-zero after reset, so it is built from
  // resettable flops rather than left to an uninitialised RAM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_ENTRIES; i++) palette[i] <= '0;
    end else if (pal_we && int'(pal_addr) < N_ENTRIES) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // Priority encoder: lowest set hit bit wins, none set selects background.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    layer_enc = LW'(N_LAYERS);
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i]) layer_enc = LW'(i);
    end
  end

  // Stage 1: register valid, resolved layer and gradient coordinate.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_layer <= '0;
      s1_xq    <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_layer <= layer_enc;
      s1_xq    <= DrawX[9:3];
    end
  end

  // Palette lookup with black for an invalid status and background gradient.
  always_comb begin
    rd_addr   = '0;
    pal_entry = '0;
    grad      = {1'b0, s1_xq};
    if (int'(disp_idx) < N_STATUS) begin
      rd_addr   = AW'(int'(disp_idx) * (N_LAYERS + 1) + int'(s1_layer));
      pal_entry = palette[rd_addr];
    end
    s2_next = pal_entry;
    if (GRAD_EN != 0 && s1_layer == LW'(N_LAYERS)) begin
      s2_next.b = (pal_entry.b > grad) ? pal_entry.b - grad : 8'd0;
    end
  end

  // Stage 2: register the looked-up colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_rgb   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_rgb   <= s2_next;
    end
  end

  // Stage 3: fade scaling; outputs hold while no valid pixel arrives.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        VGA_R <= scale_chan(s2_rgb.r, level);
        VGA_G <= scale_chan(s2_rgb.g, level);
        VGA_B <= scale_chan(s2_rgb.b, level);
      end
    end
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the combinational colour mapper.
- Takes per-pixel layer hit flags and the one-hot game status, and resolves the highest-priority layer.
- Looks the colour up in a runtime-writable per-status palette and optionally applies the horizontal background gradient.
- Screen changes fade through black instead of cutting hard; output feeds the VGA RGB pins.

Parameters:
N_LAYERS, 8, number of foreground layer flags; bit 0 has highest priority
N_STATUS, 5, number of game statuses (one-hot width)
FADE_BITS, 4, fade level resolution; full brightness = 2**FADE_BITS
FADE_STEP, 2, level change per frame during a fade
GRAD_EN, 1, 1 = background blue channel gets the DrawX gradient

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  DrawX/DrawY/layer_hit valid this cycle
frame_start  in  1  one-cycle pulse at the first pixel of each frame
status  in  N_STATUS  requested game status, one-hot
layer_hit  in  N_LAYERS  per-layer "pixel belongs to layer" flags
DrawX, DrawY  in  10 each  current pixel coordinates
pal_we  in  1  palette write strobe
pal_addr  in  clog2(N_STATUS*(N_LAYERS+1))  palette index = status_idx*(N_LAYERS+1)+layer; layer N_LAYERS = background
pal_data  in  24  {R,G,B}
VGA_R, VGA_G, VGA_B  out  8 each  composited colour
out_valid  out  1  pix_valid delayed by 3
fade_busy  out  1  fade FSM not IDLE

Behaviour:
- Reset (async, Reset_n=0):
  - VGA_R/G/B=0, out_valid=0, fade_busy=0.
  - FSM=IDLE, level=2**FADE_BITS, disp_idx=0, pend_idx=0.
  - All palette entries 0; pipeline valids cleared.
  - Reset mid-fade aborts the fade immediately.
- Pipeline, latency 3 Clk (pix_valid to out_valid), fully pipelined, one pixel per cycle:
  - S1: register inputs; priority-encode layer_hit, lowest set bit wins; no bit set → background (index N_LAYERS).
  - S2: palette read at disp_idx*(N_LAYERS+1)+layer.
    - If background and GRAD_EN, B = B_pal - {1'b0,DrawX[9:3]}, saturating at 0.
    - If disp_idx is invalid, colour = 0.
  - S3: each channel = (c*level)>>FADE_BITS, 8x(FADE_BITS+1)-bit unsigned multiply; level=2**FADE_BITS passes c unchanged.
  - Outputs hold their last value while out_valid=0.
- Status decode:
  - status one-hot → req_idx = bit position.
  - Zero or multi-hot → req_idx = INVALID, which renders black in S2.
- Fade FSM: all level updates happen only on frame_start.
  - IDLE: if req_idx != disp_idx, latch pend_idx=req_idx and go FADE_OUT; no level change that frame.
  - FADE_OUT:
    - Each frame_start: level = max(level-FADE_STEP, 0).
    - req_idx changes: pend_idx follows the latest req_idx.
    - When level reaches 0: disp_idx=pend_idx and go FADE_IN, same cycle.
  - FADE_IN:
    - Each frame_start: level = min(level+FADE_STEP, 2**FADE_BITS).
    - req_idx != disp_idx: latch pend_idx and go FADE_OUT from the current level.
    - At full: go IDLE.
  - If req_idx returns to disp_idx during FADE_OUT, the fade still completes to black and back in (no reversal).
- disp_idx changes only while level=0, so no mid-frame palette switch is visible.
- Palette write:
  - Synchronous; visible to S2 reads from the next cycle; a same-cycle read returns the old value.
  - pal_addr beyond the table is ignored.

Decomposition:
- Package compositor_pkg holds:
  - fade_state_t enum {IDLE, FADE_OUT, FADE_IN};
  - STATUS_* one-hot constants {SELECT, WAIT, PLAY, WIN, LOSE} matching the existing status bus;
  - function onehot_to_idx;
  - RGB struct type.
- One sub-module, fade_ctrl: owns the FSM, level, disp_idx, pend_idx.

Test Plan:
1. Reset release, palette unwritten, pix_valid=1 → out_valid rises 3 cycles later, RGB=000000, fade_busy=0.
2. Priority and latency: write pal[0*9+2]=FFFF00 and pal[0*9+5]=404040, status=SELECT, layer_hit=8'b00100100 → RGB FFFF00 after exactly 3 Clk; layer_hit=8'b00100000 → 404040.
3. Background gradient: pal[0*9+8]=4F4F7F, layer_hit=0, DrawX=80 → 4F4F75; B_pal=05, DrawX=639 → B=00 (saturated).
4. Fade: status SELECT→PLAY with FADE_BITS=4, FADE_STEP=2.
   - Level runs 16,14,...,0 over 8 frame_starts; disp_idx switches at 0; back to 16 after 8 more; fade_busy high throughout.
   - Mid-fade colour at level 8 with FF → 7F.
5. Re-target and abort:
   - status changes to WIN during FADE_IN at level 6 → FADE_OUT from 6; final disp_idx=WIN.
   - status=5'b00011 → black output.
   - Reset_n pulse mid-fade → level=16, IDLE.
6. Palette hazard: pal_we to the entry being read in the same cycle → that pixel shows the old colour, the next pixel the new colour.
